// File: rtl/icache_nway.sv
`default_nettype none
// ============================================================================
// Module      : icache_nway
// Description : N-way set-associative read-only instruction cache that uses
//               round-robin replacement and refills one block per burst.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_nway #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int CACHE_SIZE    = 1024,
    parameter int ASSOCIATIVITY = 4,
    parameter int BLOCK_SIZE    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    output logic [DATA_WIDTH-1:0] cpu_data,
    output logic                  cpu_valid,
    output logic                  cpu_stall,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_burst_len,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic                  mem_ready,
    input  logic                  mem_valid,
    input  logic                  mem_last,
    output logic                  cache_hit,
    output logic                  cache_miss,
    output logic                  cache_evict
);
    localparam int BYTES_PER_WORD = DATA_WIDTH / 8;
    localparam int SETS       = CACHE_SIZE / (ASSOCIATIVITY * BLOCK_SIZE * BYTES_PER_WORD);
    localparam int BYTE_BITS  = $clog2(BYTES_PER_WORD);
    localparam int WORD_BITS  = $clog2(BLOCK_SIZE);
    localparam int OFF_BITS   = BYTE_BITS + WORD_BITS;
    localparam int INDEX_BITS = $clog2(SETS);
    localparam int TAG_WIDTH  = ADDR_WIDTH - OFF_BITS - INDEX_BITS;
    localparam int WAY_BITS   = (ASSOCIATIVITY > 1) ? $clog2(ASSOCIATIVITY) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic                  r_valid [SETS][ASSOCIATIVITY];
    logic [TAG_WIDTH-1:0]  r_tag   [SETS][ASSOCIATIVITY];
    logic [DATA_WIDTH-1:0] r_data  [SETS][ASSOCIATIVITY][BLOCK_SIZE];
    logic [WAY_BITS-1:0]   r_rr    [SETS];

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [WAY_BITS-1:0]   r_victim;
    logic                  r_victim_valid;
    logic [WORD_BITS-1:0]  r_beat;
    logic                  r_evict;

    logic [INDEX_BITS-1:0] w_index;
    logic [TAG_WIDTH-1:0]  w_tag;
    logic [WORD_BITS-1:0]  w_word;
    logic [INDEX_BITS-1:0] w_fill_index;
    logic [TAG_WIDTH-1:0]  w_fill_tag;
    logic                  w_hit;
    logic [DATA_WIDTH-1:0] w_hit_data;
    logic                  w_has_invalid;
    logic [WAY_BITS-1:0]   w_free_way;
    logic [WAY_BITS-1:0]   w_victim;
    logic                  w_lookup;
    logic                  w_miss;
    logic                  w_last_beat;
    logic                  w_unused;

    assign w_index      = cpu_addr[OFF_BITS +: INDEX_BITS];
    assign w_tag        = cpu_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
    assign w_word       = cpu_addr[BYTE_BITS +: WORD_BITS];
    assign w_fill_index = r_addr[OFF_BITS +: INDEX_BITS];
    assign w_fill_tag   = r_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
    assign w_unused     = ^cpu_addr[BYTE_BITS-1:0];

    // Descending scan so the lowest-numbered invalid way wins the free slot.
    always_comb begin
        w_hit         = 1'b0;
        w_hit_data    = '0;
        w_has_invalid = 1'b0;
        w_free_way    = '0;
        for (int w = ASSOCIATIVITY - 1; w >= 0; w--) begin
            if (!r_valid[w_index][w]) begin
                w_has_invalid = 1'b1;
                w_free_way    = WAY_BITS'(w);
            end
            if (r_valid[w_index][w] && (r_tag[w_index][w] == w_tag)) begin
                w_hit      = 1'b1;
                w_hit_data = r_data[w_index][w][w_word];
            end
        end
    end

    assign w_victim    = w_has_invalid ? w_free_way : r_rr[w_index];
    assign w_lookup    = (r_state == IDLE) && cpu_req && !rst;
    assign w_miss      = w_lookup && !w_hit;
    assign w_last_beat = (r_state == FILL) && mem_valid && mem_last;
    assign cache_evict = r_evict;

    always_comb begin
        w_next_state  = r_state;
        cpu_data      = '0;
        cpu_valid     = 1'b0;
        cpu_stall     = 1'b0;
        mem_req       = 1'b0;
        mem_addr      = '0;
        mem_burst_len = '0;
        cache_hit     = 1'b0;
        cache_miss    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_lookup) begin
                    if (w_hit) begin
                        cpu_data  = w_hit_data;
                        cpu_valid = 1'b1;
                        cache_hit = 1'b1;
                    end else begin
                        cpu_stall    = 1'b1;
                        cache_miss   = 1'b1;
                        w_next_state = REQ;
                    end
                end
            end
            REQ: begin
                mem_req       = 1'b1;
                mem_addr      = r_addr;
                mem_burst_len = 4'(BLOCK_SIZE - 1);
                cpu_stall     = 1'b1;
                if (mem_ready) begin
                    w_next_state = FILL;
                end
            end
            FILL: begin
                cpu_stall = 1'b1;
                if (w_last_beat) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_addr         <= '0;
            r_victim       <= '0;
            r_victim_valid <= 1'b0;
            r_beat         <= '0;
            r_evict        <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                r_rr[s] <= '0;
                for (int w = 0; w < ASSOCIATIVITY; w++) begin
                    r_valid[s][w] <= 1'b0;
                end
            end
        end else begin
            r_state <= w_next_state;
            r_evict <= w_last_beat && r_victim_valid;
            if (w_miss) begin
                r_addr         <= {cpu_addr[ADDR_WIDTH-1:OFF_BITS], {OFF_BITS{1'b0}}};
                r_victim       <= w_victim;
                r_victim_valid <= !w_has_invalid;
                r_beat         <= '0;
                // The pointer only advances when it actually picked the victim.
                if (!w_has_invalid) begin
                    r_rr[w_index] <= (r_rr[w_index] == WAY_BITS'(ASSOCIATIVITY - 1)) ?
                                     '0 : r_rr[w_index] + WAY_BITS'(1);
                end
            end
            if ((r_state == FILL) && mem_valid) begin
                r_beat <= r_beat + WORD_BITS'(1);
            end
            if (w_last_beat) begin
                r_valid[w_fill_index][r_victim] <= 1'b1;
                r_tag[w_fill_index][r_victim]   <= w_fill_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if ((r_state == FILL) && mem_valid) begin
            r_data[w_fill_index][r_victim][r_beat] <= mem_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_icache_nway.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache_nway
// Description : Directed bench for icache_nway with a set/way array model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_nway;
    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_data;
    logic        cpu_valid;
    logic        cpu_stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [3:0]  mem_burst_len;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        mem_valid;
    logic        mem_last;
    logic        cache_hit;
    logic        cache_miss;
    logic        cache_evict;

    always #5 clk = ~clk;

    icache_nway dut (
        .clk           (clk),
        .rst           (rst),
        .cpu_req       (cpu_req),
        .cpu_addr      (cpu_addr),
        .cpu_data      (cpu_data),
        .cpu_valid     (cpu_valid),
        .cpu_stall     (cpu_stall),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_burst_len (mem_burst_len),
        .mem_data      (mem_data),
        .mem_ready     (mem_ready),
        .mem_valid     (mem_valid),
        .mem_last      (mem_last),
        .cache_hit     (cache_hit),
        .cache_miss    (cache_miss),
        .cache_evict   (cache_evict)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h required 0x%h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory image: word at byte address A holds 0x100 + A/4.
    function automatic logic [31:0] mem_word(input logic [31:0] blk, input int i);
        return 32'h100 + (blk >> 2) + 32'(i);
    endfunction

    // Model: cache contents per set/way plus the outstanding-miss phase.
    logic        m_valid [8][4];
    logic [23:0] m_tag   [8][4];
    logic [31:0] m_data  [8][4][8];
    int          m_rr    [8];
    logic        m_busy, m_accepted, m_victim_old, m_evict_next;
    logic [31:0] m_blk;
    int          m_way, m_beat;

    always @(negedge clk) begin : model
        logic [2:0]  s, wd;
        logic [23:0] t;
        int          hw;
        logic [31:0] e_data, e_maddr;
        logic [3:0]  e_len;
        logic        e_valid, e_stall, e_mreq, e_hit, e_miss;
        if (rst) begin
            foreach (m_valid[i, j]) m_valid[i][j] = 1'b0;
            foreach (m_rr[i]) m_rr[i] = 0;
            m_busy       = 1'b0;
            m_accepted   = 1'b0;
            m_evict_next = 1'b0;
        end else begin
            s  = cpu_addr[7:5];
            t  = cpu_addr[31:8];
            wd = cpu_addr[4:2];
            hw = -1;
            for (int w = 0; w < 4; w++)
                if (m_valid[s][w] && m_tag[s][w] == t) hw = w;
            e_data = '0; e_maddr = '0; e_len = '0;
            e_valid = 1'b0; e_stall = 1'b0; e_mreq = 1'b0; e_hit = 1'b0; e_miss = 1'b0;
            if (!m_busy) begin
                if (cpu_req) begin
                    if (hw >= 0) begin
                        e_valid = 1'b1;
                        e_hit   = 1'b1;
                        e_data  = m_data[s][hw][wd];
                    end else begin
                        e_stall = 1'b1;
                        e_miss  = 1'b1;
                    end
                end
            end else begin
                e_stall = 1'b1;
                if (!m_accepted) begin
                    e_mreq  = 1'b1;
                    e_maddr = m_blk;
                    e_len   = 4'd7;
                end
            end
            chk("cpu_data", cpu_data, e_data);
            chk("cpu_valid", 32'(cpu_valid), 32'(e_valid));
            chk("cpu_stall", 32'(cpu_stall), 32'(e_stall));
            chk("mem_req", 32'(mem_req), 32'(e_mreq));
            chk("mem_addr", mem_addr, e_maddr);
            chk("mem_burst_len", 32'(mem_burst_len), 32'(e_len));
            chk("cache_hit", 32'(cache_hit), 32'(e_hit));
            chk("cache_miss", 32'(cache_miss), 32'(e_miss));
            chk("cache_evict", 32'(cache_evict), 32'(m_evict_next));

            m_evict_next = 1'b0;
            if (!m_busy) begin
                if (cpu_req && hw < 0) begin
                    m_way = -1;
                    for (int w = 3; w >= 0; w--)
                        if (!m_valid[s][w]) m_way = w;
                    m_victim_old = (m_way < 0);
                    if (m_way < 0) begin
                        m_way   = m_rr[s];
                        m_rr[s] = (m_rr[s] + 1) % 4;
                    end
                    m_blk      = {cpu_addr[31:5], 5'b0};
                    m_busy     = 1'b1;
                    m_accepted = 1'b0;
                    m_beat     = 0;
                end
            end else if (!m_accepted) begin
                if (mem_ready) m_accepted = 1'b1;
            end else if (mem_valid) begin
                m_data[m_blk[7:5]][m_way][m_beat % 8] = mem_data;
                m_beat++;
                if (mem_last) begin
                    m_valid[m_blk[7:5]][m_way] = 1'b1;
                    m_tag[m_blk[7:5]][m_way]   = m_blk[31:8];
                    m_busy       = 1'b0;
                    m_evict_next = m_victim_old;
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pc(input logic [31:0] a);
        cpu_req  = 1'b1;
        cpu_addr = a;
    endtask

    task automatic handshake(input int wait_cycles);
        repeat (wait_cycles) cycle();
        mem_ready = 1'b1;
        cycle();
        mem_ready = 1'b0;
    endtask

    // Drives n beats of block blk; odd beats are preceded by an idle gap when gaps=1.
    task automatic burst(input logic [31:0] blk, input logic gaps, input int n);
        for (int i = 0; i < n; i++) begin
            if (gaps && (i % 2 == 1)) begin
                mem_valid = 1'b0;
                mem_data  = 32'hDEAD_BEEF;
                cycle();
            end
            mem_valid = 1'b1;
            mem_data  = mem_word(blk, i);
            mem_last  = (i == 7);
            cycle();
        end
        mem_valid = 1'b0;
        mem_last  = 1'b0;
        mem_data  = 32'hDEAD_BEEF;
    endtask

    task automatic fill(input logic [31:0] a);
        set_pc(a);
        cycle();
        handshake(0);
        burst({a[31:5], 5'b0}, 1'b0, 8);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cpu_req = 1'b0; cpu_addr = '0;
        mem_data = 32'hDEAD_BEEF; mem_ready = 1'b0; mem_valid = 1'b0; mem_last = 1'b0;
        repeat (2) cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_stall", 32'(cpu_stall), 32'd0);
        chk("reset_mem_req", 32'(mem_req), 32'd0);
        chk("reset_valid", 32'(cpu_valid), 32'd0);

        // Cold miss on block 0
        cycle();
        set_pc(32'h0);
        @(negedge clk);
        chk("cold_miss", 32'(cache_miss), 32'd1);
        chk("cold_stall", 32'(cpu_stall), 32'd1);
        cycle();
        @(negedge clk);
        chk("cold_mem_addr", mem_addr, 32'h0);
        chk("cold_burst_len", 32'(mem_burst_len), 32'd7);
        handshake(0);
        burst(32'h0, 1'b0, 8);
        @(negedge clk);
        chk("cold_data", cpu_data, 32'h100);
        chk("cold_hit", 32'(cache_hit), 32'd1);
        chk("cold_nostall", 32'(cpu_stall), 32'd0);

        // Hits within the block
        cycle(); set_pc(32'h04); @(negedge clk); chk("hit_04", cpu_data, 32'h101);
        cycle(); set_pc(32'h1C); @(negedge clk); chk("hit_1c", cpu_data, 32'h107);
        cycle(); set_pc(32'h1E); @(negedge clk); chk("hit_1e", cpu_data, 32'h107);
        cycle();

        // Set 0 conflicts
        fill(32'h100);
        fill(32'h200);
        fill(32'h300);
        @(negedge clk);
        chk("no_evict_300", 32'(cache_evict), 32'd0);
        cycle();
        fill(32'h400);
        @(negedge clk);
        chk("evict_400", 32'(cache_evict), 32'd1);
        chk("data_400", cpu_data, 32'h200);
        cycle();
        set_pc(32'h0);
        @(negedge clk);
        chk("remiss_000", 32'(cache_miss), 32'd1);
        cycle();
        handshake(0);
        burst(32'h0, 1'b0, 8);
        @(negedge clk);
        chk("evict_000", 32'(cache_evict), 32'd1);
        chk("data_000", cpu_data, 32'h100);
        cycle(); set_pc(32'h200); @(negedge clk); chk("hit_200", cpu_data, 32'h180);
        cycle(); set_pc(32'h100); @(negedge clk); chk("miss_100", 32'(cache_miss), 32'd1);
        cycle();
        handshake(0);
        burst(32'h100, 1'b0, 8);
        cycle();

        // Different set
        fill(32'h020);
        @(negedge clk);
        chk("data_020", cpu_data, 32'h108);
        chk("no_evict_020", 32'(cache_evict), 32'd0);
        cycle(); set_pc(32'h000); @(negedge clk); chk("set0_hit", cpu_data, 32'h100);
        cycle(); set_pc(32'h024); @(negedge clk); chk("set1_hit", cpu_data, 32'h109);
        cycle();

        // Slow handshake and gapped burst
        set_pc(32'h040);
        cycle();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("wait_mem_req", 32'(mem_req), 32'd1);
            chk("wait_stall", 32'(cpu_stall), 32'd1);
            cycle();
        end
        handshake(0);
        burst(32'h040, 1'b1, 8);
        @(negedge clk);
        chk("gap_data_0", cpu_data, 32'h110);
        cycle(); set_pc(32'h054); @(negedge clk); chk("gap_data_5", cpu_data, 32'h115);
        cycle();

        // Reset in the middle of a fill
        set_pc(32'h060);
        cycle();
        handshake(0);
        burst(32'h060, 1'b0, 3);
        rst = 1'b1;
        cpu_req = 1'b0;
        cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("idle_stall", 32'(cpu_stall), 32'd0);
        chk("idle_hit", 32'(cache_hit), 32'd0);
        chk("idle_miss", 32'(cache_miss), 32'd0);
        cycle();
        set_pc(32'h0);
        @(negedge clk);
        chk("post_rst_miss", 32'(cache_miss), 32'd1);
        cycle();
        handshake(2);
        burst(32'h0, 1'b0, 8);
        @(negedge clk);
        chk("post_rst_data", cpu_data, 32'h100);
        chk("post_rst_no_evict", 32'(cache_evict), 32'd0);
        cycle();
        cpu_req = 1'b0;
        cycle();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/icache_nway.md
Name: icache_nway

Overview:
- N-way set-associative, multi-word-block instruction cache between the CPU fetch port (PC in, instruction out, stall out) and a burst-read memory controller.
- Hits return the instruction combinationally in the same cycle.
- Misses stall the CPU, fetch the whole block as one burst, then resume.
- Read-only: no write path, no dirty state.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, instruction/word width.
- CACHE_SIZE, 1024, total data capacity in bytes.
- ASSOCIATIVITY, 4, ways per set.
- BLOCK_SIZE, 8, words per block.
- Derived at defaults: SETS = CACHE_SIZE/(ASSOCIATIVITY*BLOCK_SIZE*4) = 8.
- Address split at defaults: byte bits [1:0], word offset [4:2], index [7:5], tag [31:8].

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_req  in  1  fetch request.
- cpu_addr  in  ADDR_WIDTH  fetch address (PC).
- cpu_data  out  DATA_WIDTH  instruction word.
- cpu_valid  out  1  cpu_data is valid this cycle.
- cpu_stall  out  1  CPU must hold its PC.
- mem_req  out  1  burst request to the controller.
- mem_addr  out  ADDR_WIDTH  block-aligned burst start address.
- mem_burst_len  out  4  beats minus one (BLOCK_SIZE-1 = 7).
- mem_data  in  DATA_WIDTH  burst data beat.
- mem_ready  in  1  controller accepts the request.
- mem_valid  in  1  mem_data beat is valid.
- mem_last  in  1  final beat of the burst.
- cache_hit  out  1  one-cycle hit pulse.
- cache_miss  out  1  one-cycle miss pulse.
- cache_evict  out  1  one-cycle pulse when a valid line is replaced.

Behaviour:
- Storage: per set and way, a valid bit, a tag and BLOCK_SIZE words. Per set, a round-robin victim pointer.
- Reset: all valid bits 0; victim pointers 0; FSM to IDLE; all outputs 0. Reset in any state aborts the burst and drops mem_req next cycle.
- FSM states: IDLE, REQ, FILL.
- IDLE lookup is combinational: hit = valid && tag match in any way of set cpu_addr[index].
  - Hit with cpu_req=1: cpu_data = word at cpu_addr[word offset] of the hitting way; cpu_valid=1, cpu_stall=0, cache_hit=1.
  - Miss with cpu_req=1: cpu_stall=1 combinationally and cache_miss=1 for that cycle.
  - On a miss, latch the block-aligned address (low log2(BLOCK_SIZE*4) bits zeroed) and the victim way, then go to REQ.
  - Victim: lowest-numbered invalid way, else the set's round-robin pointer. The pointer increments (wraps) each time it is used.
  - cpu_req=0: no lookup, no stats pulses, cpu_stall=0, cpu_valid=0.
- REQ:
  - mem_req=1, mem_addr = latched address, mem_burst_len = BLOCK_SIZE-1; cpu_stall=1.
  - On mem_ready=1, go to FILL. mem_req stays high until that handshake completes.
- FILL:
  - mem_req=0; cpu_stall=1.
  - Each cycle with mem_valid=1 writes mem_data to the victim way at word index = beat counter (starts 0), then increments the counter.
  - On mem_valid && mem_last: write tag, set valid, pulse cache_evict if the victim was valid, return to IDLE.
  - mem_last marks the line valid even if fewer than BLOCK_SIZE beats arrived; the controller must supply exactly BLOCK_SIZE beats.
- After the fill, IDLE re-looks up the current cpu_addr. The hit, with cpu_stall=0, occurs the first cycle after mem_last.
- Any cpu_addr change during REQ/FILL is ignored. The latched address is fetched regardless.
- Outside IDLE-hit, cpu_data = 0 and cpu_valid = 0.
- mem_addr and mem_burst_len are 0 when not in REQ.
- No critical-word forwarding.
- Stats pulses are never asserted in REQ/FILL.

Test Plan:
- Cold miss: after reset, cpu_addr=0x0 → cache_miss pulse, stall; mem_req with mem_addr=0x0, burst_len=7; controller returns 0x100..0x107 (mem_last on beat 8) → the next cycle cpu_data=0x100, stall=0, cache_hit=1.
- Block hits: cpu_addr=0x04, 0x1C, then 0x1E after that fill → cpu_data=0x101, 0x107, 0x107, all without stall or mem_req. Addresses 0x1C and 0x1E select the same word.
- Set conflict: fill 0x000, 0x100, 0x200, 0x300 (all set 0) → no cache_evict. Fill 0x400 → cache_evict pulse, way 0 replaced. Then 0x000 → miss; its fill evicts way 1.
- Different sets: 0x000 and 0x020 both fill; each then hits independently with no eviction.
- Handshake: hold mem_ready=0 for 5 cycles in REQ → mem_req stays 1, stall stays 1. Insert mem_valid gaps in FILL → words land at the correct offsets.
- Reset mid-fill after 3 beats → mem_req=0, all lines invalid. Re-access 0x0 → misses again. cpu_req=0 → stall=0, no hit/miss pulses.
